// File: rtl/mod_arith_pkg.sv
// Shared constants and state encoding for the limb-serial modular arithmetic stages.
// Operands are zero-extended to W = NLIMB*LIMB_W bits so an (N+1)-bit sum always fits.
package mod_arith_pkg;

    localparam int N      = 1027;
    localparam int LIMB_W = 64;
    localparam int NLIMB  = (N + 1 + LIMB_W - 1) / LIMB_W;
    localparam int W      = NLIMB * LIMB_W;
    localparam int CNT_W  = $clog2(NLIMB);

    typedef enum logic [1:0] {
        IDLE,
        PH1,
        PH2,
        SEL
    } state_t;

    function automatic logic is_last_limb(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(NLIMB - 1);
    endfunction

endpackage

// File: rtl/limb_adder.sv
// Purely combinational LIMB_W-bit adder with carry in/out.
// A single instance is time-shared by both phases of mod_addsub.
module limb_adder
    import mod_arith_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] s,
    output logic              cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};

endmodule

// File: rtl/mod_addsub.sv
// Limb-serial modular add/subtract: R = (A +/- B) mod M for A, B < M, M odd.
// Phase 1 forms T = A +/- B, phase 2 forms U = T -/+ M, and SEL picks T or U by the carries.
module mod_addsub
    import mod_arith_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done
);

    state_t state, next_state;

    logic [W-1:0]      a_sr;
    logic [W-1:0]      b_sr;
    logic [W-1:0]      m_sr;
    logic [W-1:0]      t_sr;
    logic [W-1:0]      u_sr;
    logic [CNT_W-1:0]  cnt;
    logic              c;
    logic              flag1;
    logic              flag2;
    logic              sub_q;

    logic [LIMB_W-1:0] op_a;
    logic [LIMB_W-1:0] op_b;
    logic [LIMB_W-1:0] sum;
    logic              cout;
    logic              last;
    logic              take_u;
    logic [N-1:0]      selected;

    assign last = is_last_limb(cnt);
    assign busy = (state != IDLE);

    // Phase 2 reads T from the rotating register and adds M (sub) or ~M (add).
    always_comb begin
        op_a = a_sr[LIMB_W-1:0];
        op_b = b_sr[LIMB_W-1:0];
        if (state == PH2) begin
            op_a = t_sr[LIMB_W-1:0];
            op_b = sub_q ? m_sr[LIMB_W-1:0] : ~m_sr[LIMB_W-1:0];
        end
    end

    limb_adder u_limb_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (c),
        .s    (sum),
        .cout (cout)
    );

    always_comb begin
        take_u   = sub_q ? ~flag1 : flag2;
        selected = take_u ? u_sr[N-1:0] : t_sr[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PH1;
            PH1:     if (last)  next_state = PH2;
            PH2:     if (last)  next_state = SEL;
            SEL:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operands shift out low limb first; T and U fill from the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            m_sr   <= '0;
            t_sr   <= '0;
            u_sr   <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            flag1  <= 1'b0;
            flag2  <= 1'b0;
            sub_q  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= {{(W-N){1'b0}}, in_a};
                        b_sr  <= subtract ? ~{{(W-N){1'b0}}, in_b} : {{(W-N){1'b0}}, in_b};
                        m_sr  <= {{(W-N){1'b0}}, in_m};
                        sub_q <= subtract;
                        c     <= subtract;
                        cnt   <= '0;
                    end
                end
                PH1: begin
                    a_sr <= a_sr >> LIMB_W;
                    b_sr <= b_sr >> LIMB_W;
                    t_sr <= {sum, t_sr[W-1:LIMB_W]};
                    if (last) begin
                        flag1 <= cout;
                        c     <= ~sub_q;
                        cnt   <= '0;
                    end else begin
                        c   <= cout;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PH2: begin
                    t_sr <= {t_sr[LIMB_W-1:0], t_sr[W-1:LIMB_W]};
                    m_sr <= m_sr >> LIMB_W;
                    u_sr <= {sum, u_sr[W-1:LIMB_W]};
                    c    <= cout;
                    if (last) begin
                        flag2 <= cout;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SEL: begin
                    result <= selected;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub.sv
// Directed and randomized bench for mod_addsub: vector table, back-to-back ops,
// ignored starts while busy, and reset abort in the middle of phase 2.
module tb_mod_addsub;
    import mod_arith_pkg::*;

    localparam int LAT = 2 * NLIMB + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         subtract;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_m;
    logic [N-1:0] result;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string        name;
        logic         sub;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] m;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    mod_addsub dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_m     (in_m),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
                     name, act[N-1:N-4], act[127:0], exp[N-1:N-4], exp[127:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_model(input logic sub, input logic [N-1:0] a,
                                               input logic [N-1:0] b, input logic [N-1:0] m);
        logic [N:0] s;
        if (!sub) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, m}) s = s - {1'b0, m};
        end else if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_below_2_1026();
        logic [1055:0] tmp;
        for (int i = 0; i < 33; i++) tmp[i*32 +: 32] = $urandom;
        return {1'b0, tmp[1025:0]};
    endfunction

    task automatic add_vec(input string name, input logic sub, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic [N-1:0] m, input logic [N-1:0] exp);
        vec_t v;
        v.name = name; v.sub = sub; v.a = a; v.b = b; v.m = m; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Called #1 after an edge; returns in the done cycle (or after a timeout).
    task automatic apply_stimulus(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [N-1:0] m, output int lat, output int busy_ok,
                                  output int stable_ok, output logic [N-1:0] r0);
        start = 1'b1; subtract = sub; in_a = a; in_b = b; in_m = m;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_ok = 1; stable_ok = 1;
        r0 = result;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 0;
            if (result !== r0) stable_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_and_check(input string name, input logic sub, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic [N-1:0] m,
                                 input logic [N-1:0] exp, input logic [N-1:0] prev);
        int lat, busy_ok, stable_ok;
        logic [N-1:0] r0;
        apply_stimulus(sub, a, b, m, lat, busy_ok, stable_ok, r0);
        check_int({name, " latency"}, lat, LAT);
        check_int({name, " busy"}, busy_ok, 1);
        check_int({name, " busy_low_at_done"}, int'(busy), 0);
        check_output({name, " held_prev"}, r0, prev);
        check_int({name, " stable"}, stable_ok, 1);
        check_output({name, " result"}, result, exp);
    endtask

    initial begin
        logic [N-1:0] one, m0, mmax, m3, prev, a, b, m, exp;
        logic         sub;
        int           dones;

        one  = 1;
        m0   = (one << 1026) + N'(5);
        mmax = '1;
        m3   = N'(3);

        add_vec("add_small",    1'b0, N'(3),      N'(4),  m0,   N'(7));
        add_vec("add_carry",    1'b0, m0 - one,   N'(2),  m0,   N'(1));
        add_vec("sub_borrow",   1'b1, N'(3),      N'(5),  m0,   (one << 1026) + N'(3));
        add_vec("sub_equal",    1'b1, N'(5),      N'(5),  m0,   N'(0));
        add_vec("add_max",      1'b0, m0 - one,   m0 - one, m0, m0 - N'(2));
        add_vec("add_wrap_max", 1'b0, mmax - one, one,    mmax, N'(0));
        add_vec("sub_zero_a",   1'b1, N'(0),      mmax - one, mmax, one);
        add_vec("sub_no_borrow",1'b1, mmax - one, N'(0),  mmax, mmax - one);
        add_vec("add_m3",       1'b0, N'(2),      N'(2),  m3,   N'(1));
        add_vec("sub_m3",       1'b1, N'(0),      N'(1),  m3,   N'(2));

        reset = 1'b1; start = 1'b0; subtract = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset result", result, '0);
        check_int("reset busy", int'(busy), 0);
        check_int("reset done", int'(done), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Each vector is started in the done cycle of the previous one.
        prev = '0;
        foreach (vecs[i]) begin
            run_and_check(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].m,
                          vecs[i].exp, prev);
            prev = vecs[i].exp;
        end

        for (int k = 0; k < 8; k++) begin
            m   = {1'b1, rand_below_2_1026()} | one;
            a   = rand_below_2_1026();
            b   = (k == 3) ? a : rand_below_2_1026();
            sub = 1'(k % 2);
            exp = ref_model(sub, a, b, m);
            run_and_check($sformatf("rand%0d", k), sub, a, b, m, exp, prev);
            prev = exp;
        end

        @(posedge clk); #1;
        check_int("done_clears", int'(done), 0);
        check_output("result_hold", result, prev);

        // Starts during an active operation must not disturb it.
        start = 1'b1; subtract = 1'b0; in_a = N'(3); in_b = N'(4); in_m = m0;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int e = 1; e <= 45; e++) begin
            if (e == 5 || e == 20) begin
                start = 1'b1; subtract = 1'b1; in_a = N'(99); in_b = N'(1); in_m = m0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) dones++;
        end
        check_int("ignored_start done_count", dones, 1);
        check_output("ignored_start result", result, N'(7));
        check_int("ignored_start idle", int'(busy), 0);

        // Reset while phase 2 is working on limb 8.
        start = 1'b1; subtract = 1'b0; in_a = N'(3); in_b = N'(4); in_m = m0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (NLIMB + 8) @(posedge clk);
        #1;
        check_int("pre_abort busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_int("abort busy", int'(busy), 0);
        check_int("abort done", int'(done), 0);
        check_output("abort result", result, '0);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check_int("abort no_done", dones, 0);
        run_and_check("after_abort", 1'b1, N'(3), N'(5), m0, (one << 1026) + N'(3), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
